// File: rtl/apb4_reg_slave.sv
// apb4_reg_slave: APB4 completer with a register bank, programmable wait states, byte strobes and error response
module apb4_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS = 16,
  parameter int WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE = 32'hA9B4_0001
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [STRB_WIDTH-1:0]          pstrb,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic                           wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0]    wr_index
);
  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ADDR_WIDTH'((1 << LSB) - 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, cur_idx;
  logic wr, err, cur_wr, cur_err, a_err, setup, commit;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  assign setup = psel && !penable;
  assign a_err = (|(paddr & ALIGN)) || (|(paddr >> (LSB + IW))) || (pwrite && paddr[LSB +: IW] == '0);
  // with zero wait states the transfer completes before the setup sample is latched
  assign cur_idx = state == IDLE ? paddr[LSB +: IW] : idx;
  assign cur_wr = state == IDLE ? pwrite : wr;
  assign cur_err = state == IDLE ? a_err : err;
  assign commit = state == DONE && wr && !err;
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    case (state)
      IDLE: if (setup) begin
        cnt_nxt = 3'(WAIT_STATES);
        nxt = WAIT_STATES == 0 ? DONE : WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt - 3'd1;
        nxt = !psel ? IDLE : cnt == 3'd1 ? DONE : WAIT;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      wr <= 1'b0;
      err <= 1'b0;
      prdata <= '0;
      pready <= 1'b0;
      pslverr <= 1'b0;
      wr_pulse <= 1'b0;
      wr_index <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= i == 0 ? DATA_WIDTH'(ID_VALUE) : '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      if (state == IDLE && setup) begin
        idx <= paddr[LSB +: IW];
        wr <= pwrite;
        err <= a_err;
      end
      pready <= nxt == DONE;
      pslverr <= nxt == DONE && cur_err;
      prdata <= nxt == DONE && !cur_wr && !cur_err ? regs[cur_idx] : '0;
      wr_pulse <= commit;
      if (commit) begin
        wr_index <= idx;
        for (int b = 0; b < STRB_WIDTH; b++)
          if (pstrb[b]) regs[idx][8*b +: 8] <= pwdata[8*b +: 8];
      end
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
endmodule

// File: tb/tb_apb4_reg_slave.sv
// tb_apb4_reg_slave: two completers (1 and 3 wait states) checked every cycle against a transaction-level model
module tb_apb4_reg_slave;
  localparam logic [31:0] ID = 32'hA9B4_0001;
  logic clk = 0;
  always #5 clk = ~clk;
  logic preset [2], psel [2], penable [2], pwrite [2];
  logic [31:0] paddr [2], pwdata [2], prdata [2];
  logic [3:0] pstrb [2], wr_index [2];
  logic pready [2], pslverr [2], wr_pulse [2];
  logic [511:0] reg_q [2];
  apb4_reg_slave #(.WAIT_STATES(1)) dut0 (
    .pclk(clk), .preset(preset[0]), .paddr(paddr[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .reg_q(reg_q[0]), .wr_pulse(wr_pulse[0]), .wr_index(wr_index[0]));
  apb4_reg_slave #(.WAIT_STATES(3)) dut1 (
    .pclk(clk), .preset(preset[1]), .paddr(paddr[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .reg_q(reg_q[1]), .wr_pulse(wr_pulse[1]), .wr_index(wr_index[1]));
  // model: register contents plus the outputs required in the current cycle
  logic [31:0] mregs [2][16];
  logic e_rdy [2], e_err [2], e_wp [2], pend [2];
  logic [31:0] e_rd [2], p_data [2];
  logic [3:0] e_wi [2], p_idx [2], p_strb [2];
  int checks = 0, errors = 0;
  logic chk_en = 0;
  logic [31:0] rd;
  logic er, rdy;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) for (int d = 0; d < 2; d++) begin
    chk($sformatf("pready%0d", d), 32'(pready[d]), 32'(e_rdy[d]));
    chk($sformatf("pslverr%0d", d), 32'(pslverr[d]), 32'(e_err[d]));
    chk($sformatf("prdata%0d", d), prdata[d], e_rd[d]);
    chk($sformatf("wr_pulse%0d", d), 32'(wr_pulse[d]), 32'(e_wp[d]));
    if (e_wp[d]) chk($sformatf("wr_index%0d", d), 32'(wr_index[d]), 32'(e_wi[d]));
    for (int i = 0; i < 16; i++) chk($sformatf("reg_q%0d[%0d]", d, i), reg_q[d][32*i +: 32], mregs[d][i]);
  end
  // advance one cycle: apply reset or the write committed at the previous edge
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      e_rdy[d] = 0; e_err[d] = 0; e_rd[d] = 0; e_wp[d] = 0;
      psel[d] = 0; penable[d] = 0;
      if (preset[d]) begin
        for (int i = 0; i < 16; i++) mregs[d][i] = i == 0 ? ID : 32'h0;
        pend[d] = 0; e_wi[d] = 0;
      end else if (pend[d]) begin
        for (int b = 0; b < 4; b++) if (p_strb[d][b]) mregs[d][p_idx[d]][8*b +: 8] = p_data[d][8*b +: 8];
        e_wp[d] = 1; e_wi[d] = p_idx[d]; pend[d] = 0;
      end
    end
  endtask
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] s, input int ab, output logic [31:0] r, output logic e_o, output logic rdy_o);
    int ws;
    logic e;
    logic [3:0] ix;
    ws = d == 0 ? 1 : 3;
    ix = a[5:2];
    e = a[1:0] != 0 || (a >> 6) != 0 || (w && ix == 0);
    r = 0; e_o = 0; rdy_o = 0;
    tick();
    psel[d] = 1; paddr[d] = a; pwrite[d] = w; pwdata[d] = wd; pstrb[d] = s;
    for (int k = 1; k <= ws + 1; k++) begin
      tick();
      if (k == ab) return;
      psel[d] = 1; penable[d] = 1;
      if (k == ws + 1) begin
        e_rdy[d] = 1; e_err[d] = e;
        e_rd[d] = (!w && !e) ? mregs[d][ix] : 32'h0;
        if (w && !e) begin pend[d] = 1; p_idx[d] = ix; p_data[d] = wd; p_strb[d] = s; end
        @(negedge clk);
        r = prdata[d]; e_o = pslverr[d]; rdy_o = pready[d];
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    for (int d = 0; d < 2; d++) begin
      preset[d] = 1; psel[d] = 0; penable[d] = 0; pwrite[d] = 0;
      paddr[d] = 0; pwdata[d] = 0; pstrb[d] = 0; pend[d] = 0;
    end
    tick();
    chk_en = 1;
    preset[0] = 0; preset[1] = 0;
    tick();
    @(negedge clk);
    chk("rst_id", reg_q[0][31:0], ID);
    chk("rst_r1", reg_q[0][63:32], 32'h0);
    chk("rst_rdy", 32'(pready[0]), 32'h0);
    xfer(0, 32'h4, 1, 32'h1234_5678, 4'hF, 0, rd, er, rdy);
    chk("w1_rdy", 32'(rdy), 32'h1);
    chk("w1_err", 32'(er), 32'h0);
    tick();
    @(negedge clk);
    chk("w1_regq", reg_q[0][63:32], 32'h1234_5678);
    chk("w1_pulse", 32'(wr_pulse[0]), 32'h1);
    chk("w1_index", 32'(wr_index[0]), 32'h1);
    xfer(0, 32'h4, 0, 32'h0, 4'hF, 0, rd, er, rdy);
    chk("r1_data", rd, 32'h1234_5678);
    chk("r1_err", 32'(er), 32'h0);
    xfer(0, 32'h4, 1, 32'hAABB_CCDD, 4'b0101, 0, rd, er, rdy);
    xfer(0, 32'h4, 0, 32'h0, 4'h0, 0, rd, er, rdy);
    chk("partial", rd, 32'h12BB_56DD);
    xfer(0, 32'h4, 1, 32'hFFFF_FFFF, 4'h0, 0, rd, er, rdy);
    chk("nostrb_err", 32'(er), 32'h0);
    xfer(0, 32'h4, 0, 32'h0, 4'hF, 0, rd, er, rdy);
    chk("nostrb_data", rd, 32'h12BB_56DD);
    chk("model_r1", mregs[0][1], 32'h12BB_56DD);
    xfer(0, 32'h40, 1, 32'h1111_1111, 4'hF, 0, rd, er, rdy);
    chk("err_range", 32'(er), 32'h1);
    xfer(0, 32'h2, 1, 32'h2222_2222, 4'hF, 0, rd, er, rdy);
    chk("err_align", 32'(er), 32'h1);
    xfer(0, 32'h0, 1, 32'h3333_3333, 4'hF, 0, rd, er, rdy);
    chk("err_ro", 32'(er), 32'h1);
    xfer(0, 32'h0, 0, 32'h0, 4'hF, 0, rd, er, rdy);
    chk("id_data", rd, ID);
    chk("id_err", 32'(er), 32'h0);
    xfer(0, 32'h8, 1, 32'hDEAD_BEEF, 4'hF, 0, rd, er, rdy);
    xfer(0, 32'h8, 0, 32'h0, 4'hF, 0, rd, er, rdy);
    chk("b2b_data", rd, 32'hDEAD_BEEF);
    xfer(1, 32'hC, 1, 32'h0000_00C3, 4'hF, 0, rd, er, rdy);
    xfer(1, 32'hC, 1, 32'hFFFF_FFFF, 4'hF, 2, rd, er, rdy);
    xfer(1, 32'hC, 0, 32'h0, 4'hF, 0, rd, er, rdy);
    chk("abort_data", rd, 32'h0000_00C3);
    chk("abort_rdy", 32'(rdy), 32'h1);
    chk("model_r3", mregs[1][3], 32'h0000_00C3);
    xfer(1, 32'h10, 1, 32'h0000_0055, 4'hF, 0, rd, er, rdy);
    tick();
    psel[1] = 1; paddr[1] = 32'h10; pwrite[1] = 1; pwdata[1] = 32'h77; pstrb[1] = 4'hF;
    tick();
    psel[1] = 1; penable[1] = 1;
    tick();
    psel[1] = 1; penable[1] = 1; preset[1] = 1;
    tick();
    preset[1] = 0;
    @(negedge clk);
    chk("mrst_r4", reg_q[1][159:128], 32'h0);
    chk("mrst_id", reg_q[1][31:0], ID);
    chk("mrst_rdy", 32'(pready[1]), 32'h0);
    xfer(1, 32'h10, 0, 32'h0, 4'hF, 0, rd, er, rdy);
    chk("mrst_read", rd, 32'h0);
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb4_reg_slave.md
# apb4_reg_slave

APB4 completer (slave end) implementing a bank of word-addressed control registers with programmable wait states, byte strobes and error response. It connects to the slave side of the team's APB4 interface, downstream of the bridge that acts as requester. It exposes all register contents to fabric logic as a flat vector.

## Interface

Parameters:

- ADDR_WIDTH, 32: paddr width.
- DATA_WIDTH, 32: data width; must be 32 or 64.
- STRB_WIDTH, DATA_WIDTH/8: pstrb width.
- NUM_REGS, 16: number of registers; power of 2, ≥2.
- WAIT_STATES, 1: access-phase cycles with pready low before completion; range 0..7.
- ID_VALUE, 32'hA9B4_0001: constant read from register 0, zero-extended to DATA_WIDTH.

Ports:

- pclk, in, 1: clock. One clock; reset is synchronous and active-high.
- preset, in, 1: synchronous active-high reset.
- paddr, in, ADDR_WIDTH: byte address.
- psel, in, 1: select.
- penable, in, 1: access phase.
- pwrite, in, 1: 1 = write.
- pwdata, in, DATA_WIDTH: write data.
- pstrb, in, STRB_WIDTH: write byte enables.
- prdata, out, DATA_WIDTH: read data; reset 0.
- pready, out, 1: transfer complete; reset 0.
- pslverr, out, 1: error on completing cycle; reset 0.
- reg_q, out, NUM_REGS*DATA_WIDTH: register i at bits [i*DATA_WIDTH +: DATA_WIDTH]. Reset: all 0 except slice 0 = ID_VALUE.
- wr_pulse, out, 1: one-cycle strobe on a successful write commit; reset 0.
- wr_index, out, clog2(NUM_REGS): index of the committed register, valid with wr_pulse; reset 0.

## Operation

- LSB = clog2(STRB_WIDTH). index = paddr[LSB +: clog2(NUM_REGS)].
- Error conditions, evaluated on the setup-phase sample:
  - paddr[LSB-1:0] != 0 (misaligned).
  - paddr bits above index nonzero (out of range).
  - Write to index 0 (read-only ID).
- FSM states:
  - IDLE: psel & !penable → load wait counter with WAIT_STATES, latch addr/write/error → WAIT (or DONE if WAIT_STATES=0).
  - WAIT: pready=0. Counter decrements each cycle → DONE when counter reaches 1.
  - DONE: pready, prdata and pslverr are driven for exactly one cycle → IDLE.
- If psel is sampled low in WAIT, the transfer aborts: → IDLE, no write, pready stays 0.
- Write commit happens at the edge ending the pready=1 cycle, and only when there is no error. For each byte b with pstrb[b]=1, the register byte is replaced by the pwdata byte. pstrb=0 is a legal no-op write: no error, wr_pulse still asserted.
- wr_pulse and wr_index are registered, asserted in the cycle after the commit.
- Reads: prdata is the register value sampled at the edge raising pready. prdata is 0 when pready=0, for error reads, and for writes. Read strobes are ignored.
- pslverr=1 only with pready=1. An errored write changes nothing and produces no wr_pulse.
- Back-to-back transfers: a new setup phase in the cycle after pready is accepted from IDLE with no bubble.
- Reset asserted mid-transfer: next cycle → IDLE, every output at its reset value, and any pending write is discarded.

## Timing

- Setup in cycle T0 and first access in T1. pready=1 in cycle T1+WAIT_STATES.
- Total transfer length is 2+WAIT_STATES cycles.
- Write data is visible on reg_q in cycle T2+WAIT_STATES, coincident with wr_pulse.
- Read-after-write back-to-back returns the new value.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Reset, then hold: pready=0, pslverr=0, prdata=0, reg_q slice0=32'hA9B4_0001, other slices 0.
- WAIT_STATES=1: write 0x1234_5678 to paddr 0x4, pstrb=4'hF. pready is high in the 2nd access cycle. reg_q slice1=0x1234_5678, with wr_pulse=1 and wr_index=1 one cycle later. A read of 0x4 returns 0x1234_5678, pslverr=0.
- Partial strobe: reg1=0x1234_5678, then write 0xAABB_CCDD with pstrb=4'b0101. A read returns 0x12BB_56DD.
- Errors: write to 0x40 (NUM_REGS=16), write to 0x2, and write to 0x0 each complete with pslverr=1 and no reg_q change. A read of 0x0 returns ID_VALUE with pslverr=0.
- Abort: in WAIT_STATES=3, drop psel in the 2nd access cycle. No pready, reg unchanged, and the next transfer completes normally.
- Back-to-back write 0x8 then read 0x8 with no idle cycle returns the written data. Asserting preset mid-WAIT returns all outputs to reset values.
